// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised single-port RAM.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int WM_NO_CHANGE     = 0;
  localparam int WM_WRITE_THROUGH = 1;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: after reset, walks every location once writing zero,
// then hands the array over to the user port by raising o_ready.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_clr_we,
  output logic              o_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_clr_we    = 1'b0;
    o_ready     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // The reset edge itself must not count as a clear step.
        o_clr_we = ~i_rst;
        if (r_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_ready = 1'b1;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with post-reset clear sequencer.
// Define RAM_SP_OUT_REG_EN to add an output register stage (read latency 2).
module ram_sp_param
  import ram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int WRITE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  output logic              ready,
  output logic              err
);

  localparam logic WT = (WRITE_MODE == WM_WRITE_THROUGH);

  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_acc;
  logic              w_in_range;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic [DATA_W-1:0] r_out_p0;
  logic              r_vld_p0;
  logic              r_err_p0;

  ram_clear_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_clr_addr (w_clr_addr),
    .o_clr_we   (w_clr_we),
    .o_ready    (w_ready)
  );

  assign ready      = w_ready;
  assign w_acc      = en & w_ready;
  assign w_in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

  // Clear port has priority; user requests are only accepted once ready is up.
  assign w_we    = w_clr_we | (w_acc & rw & w_in_range);
  assign w_waddr = w_clr_we ? w_clr_addr : addr;
  assign w_wdata = w_clr_we ? '0 : data;
  assign w_rdata = w_in_range ? r_mem[addr] : '0;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Stage p0: array read / write-through capture, valid and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_p0 <= '0;
      r_vld_p0 <= 1'b0;
      r_err_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_acc & (~rw | WT);
      if (w_acc & ~rw)
        r_out_p0 <= w_rdata;
      else if (w_acc & rw & WT)
        r_out_p0 <= w_in_range ? data : '0;
      if (w_acc & ~w_in_range) r_err_p0 <= 1'b1;
    end
  end

`ifdef RAM_SP_OUT_REG_EN
  logic [DATA_W-1:0] r_out_p1;
  logic              r_vld_p1;
  logic              r_err_p1;

  // Stage p1: optional output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_p1 <= '0;
      r_vld_p1 <= 1'b0;
      r_err_p1 <= 1'b0;
    end else begin
      r_out_p1 <= r_out_p0;
      r_vld_p1 <= r_vld_p0;
      r_err_p1 <= r_err_p0;
    end
  end

  assign out   = r_out_p1;
  assign valid = r_vld_p1;
  assign err   = r_err_p1;
`else
  assign out   = r_out_p0;
  assign valid = r_vld_p0;
  assign err   = r_err_p0;
`endif

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: three instances (default, write-through,
// DEPTH=48) driven from a vector table plus hand-written reset sequences.
module tb_ram_sp_param;

`ifdef RAM_SP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a   [3];
  logic       rw_a   [3];
  logic [5:0] addr_a [3];
  logic [7:0] data_a [3];
  logic [7:0] out_a  [3];
  logic       vld_a  [3];
  logic       rdy_a  [3];
  logic       err_a  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_sp_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .WRITE_MODE(0)) u_nc (
    .clk(clk), .rst(rst), .en(en_a[0]), .rw(rw_a[0]), .addr(addr_a[0]),
    .data(data_a[0]), .out(out_a[0]), .valid(vld_a[0]), .ready(rdy_a[0]), .err(err_a[0]));

  ram_sp_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .WRITE_MODE(1)) u_wt (
    .clk(clk), .rst(rst), .en(en_a[1]), .rw(rw_a[1]), .addr(addr_a[1]),
    .data(data_a[1]), .out(out_a[1]), .valid(vld_a[1]), .ready(rdy_a[1]), .err(err_a[1]));

  ram_sp_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .WRITE_MODE(0)) u_d48 (
    .clk(clk), .rst(rst), .en(en_a[2]), .rw(rw_a[2]), .addr(addr_a[2]),
    .data(data_a[2]), .out(out_a[2]), .valid(vld_a[2]), .ready(rdy_a[2]), .err(err_a[2]));

  typedef struct {
    int         inst;
    bit         rw;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] exp_out;
    bit         exp_vld;
    bit         exp_err;
  } vec_t;

  vec_t vec [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue vec[lo..hi-1] on consecutive cycles; check each response LAT edges later.
  task automatic run_seq(input int lo, input int hi);
    int n;
    int inst;
    int j;
    n    = hi - lo;
    inst = vec[lo].inst;
    for (int e = 0; e < n + LAT - 1; e++) begin
      if (e < n) begin
        en_a[inst]   = 1'b1;
        rw_a[inst]   = vec[lo+e].rw;
        addr_a[inst] = vec[lo+e].addr;
        data_a[inst] = vec[lo+e].data;
      end else begin
        en_a[inst] = 1'b0;
      end
      @(posedge clk); #1;
      j = e - (LAT - 1);
      if (j >= 0) begin
        chk($sformatf("v%0d_out", lo + j), 32'(out_a[inst]), 32'(vec[lo+j].exp_out));
        chk($sformatf("v%0d_valid", lo + j), 32'(vld_a[inst]), 32'(vec[lo+j].exp_vld));
        chk($sformatf("v%0d_err", lo + j), 32'(err_a[inst]), 32'(vec[lo+j].exp_err));
      end
    end
    en_a[inst] = 1'b0;
  endtask

  // Count edges after rst falls until ready, pulsing ignored writes on u_nc early on.
  task automatic wait_ready(input string tag);
    int n0;
    int n2;
    n0 = 0;
    n2 = 0;
    for (int c = 1; c <= 200; c++) begin
      en_a[0]   = (c < 40) && (c % 3 == 0);
      rw_a[0]   = 1'b1;
      addr_a[0] = 6'h24;
      data_a[0] = 8'h33;
      @(posedge clk); #1;
      if (rdy_a[0] && n0 == 0) n0 = c;
      if (rdy_a[2] && n2 == 0) n2 = c;
      if (!rdy_a[0] && n0 != 0) n0 = -1;
      if (n0 != 0 && n2 != 0) break;
    end
    en_a[0] = 1'b0;
    chk({tag, "_ready_edges64"}, 32'(n0), 32'd64);
    chk({tag, "_ready_edges48"}, 32'(n2), 32'd48);
  endtask

  initial begin
    logic seen_vld;
    for (int i = 0; i < 3; i++) begin
      en_a[i] = 1'b0; rw_a[i] = 1'b0; addr_a[i] = '0; data_a[i] = '0;
    end

    // inst, rw, addr, data, exp_out, exp_vld, exp_err
    vec[0]  = '{0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[1]  = '{0, 1'b0, 6'h24, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[2]  = '{0, 1'b0, 6'h3F, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[3]  = '{0, 1'b0, 6'h05, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[4]  = '{0, 1'b0, 6'h24, 8'h00, 8'h48, 1'b1, 1'b0};
    vec[5]  = '{0, 1'b0, 6'h02, 8'h00, 8'h04, 1'b1, 1'b0};
    vec[6]  = '{0, 1'b0, 6'h3F, 8'h00, 8'h7E, 1'b1, 1'b0};
    vec[7]  = '{0, 1'b1, 6'h10, 8'hA5, 8'h7E, 1'b0, 1'b0};
    vec[8]  = '{0, 1'b0, 6'h10, 8'h00, 8'hA5, 1'b1, 1'b0};
    vec[9]  = '{1, 1'b1, 6'h10, 8'hA5, 8'hA5, 1'b1, 1'b0};
    vec[10] = '{1, 1'b0, 6'h10, 8'h00, 8'hA5, 1'b1, 1'b0};
    vec[11] = '{1, 1'b0, 6'h11, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[12] = '{2, 1'b0, 6'h2F, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[13] = '{2, 1'b1, 6'h30, 8'hFF, 8'h00, 1'b0, 1'b1};
    vec[14] = '{2, 1'b0, 6'h30, 8'h00, 8'h00, 1'b1, 1'b1};
    vec[15] = '{2, 1'b0, 6'h2F, 8'h00, 8'h00, 1'b1, 1'b1};
    vec[16] = '{0, 1'b0, 6'h24, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[17] = '{0, 1'b0, 6'h02, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[18] = '{0, 1'b0, 6'h3F, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[19] = '{0, 1'b0, 6'h10, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[20] = '{2, 1'b0, 6'h2F, 8'h00, 8'h00, 1'b1, 1'b0};

    // Reset state
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_out%0d", i),   32'(out_a[i]), 32'd0);
      chk($sformatf("rst_valid%0d", i), 32'(vld_a[i]), 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(rdy_a[i]), 32'd0);
      chk($sformatf("rst_err%0d", i),   32'(err_a[i]), 32'd0);
    end
    rst = 1'b0;
    wait_ready("clr1");

    // Cleared contents, including the location hit by en pulses during clear
    run_seq(0, 4);

    // Fill addr k with 2k; no-change writes must not pulse valid
    seen_vld = 1'b0;
    for (int k = 1; k < 64; k++) begin
      en_a[0] = 1'b1; rw_a[0] = 1'b1; addr_a[0] = 6'(k); data_a[0] = 8'(2 * k);
      @(posedge clk); #1;
      seen_vld = seen_vld | vld_a[0];
    end
    en_a[0] = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
      seen_vld = seen_vld | vld_a[0];
    end
    chk("fill_no_valid", 32'(seen_vld), 32'd0);

    run_seq(4, 9);
    @(posedge clk); #1;
    chk("valid_single_pulse", 32'(vld_a[0]), 32'd0);
    chk("out_holds", 32'(out_a[0]), 32'hA5);

    run_seq(9, 12);
    run_seq(12, 16);

    // Reset in RUN, then reset again at clear counter 20
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rrun_ready", 32'(rdy_a[0]), 32'd0);
    chk("rrun_out", 32'(out_a[0]), 32'd0);
    chk("rrun_err", 32'(err_a[2]), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_clear_ready", 32'(rdy_a[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready("clr2");

    run_seq(16, 20);
    run_seq(20, 21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
